// File: rtl/vga_clkgen_pkg.sv
// Shared types and constants for the DCM_CLKGEN reprogramming sequencer.
package vga_clkgen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadD,
        StGap1,
        StLoadM,
        StGap2,
        StGo,
        StWaitDone,
        StWaitLock
    } state_e;

    localparam logic [1:0]  CMD_LOAD_D = 2'b10;
    localparam logic [1:0]  CMD_LOAD_M = 2'b11;
    localparam int unsigned FRAME_LEN  = 10;
    localparam int unsigned GAP_LEN    = 2;

    // Frame in transmit order from bit 9 down: command MSB first, then value LSB first.
    function automatic logic [9:0] frame_bits(input logic [1:0] cmd, input logic [7:0] val);
        logic [9:0] f;
        f[9:8] = cmd;
        for (int i = 0; i < 8; i++) begin
            f[7-i] = val[i];
        end
        return f;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop bit synchroniser with asynchronous active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vga_clkgen_prog.sv
// DCM_CLKGEN serial reprogramming sequencer: loads D and M, issues GO, waits for
// PROGDONE and LOCKED, and holds the VGA-domain reset while the pixel clock is invalid.
module vga_clkgen_prog
    import vga_clkgen_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] cfg_m,
    input  logic [7:0] cfg_d,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    input  logic       dcm_locked,
    output logic       vga_rst
);

    localparam int unsigned PhW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PhW-1:0] PhMax = PhW'(CLK_DIV - 1);
    localparam logic [31:0] TmoLast  = 32'(TIMEOUT - 1);

    logic done_s, locked_s;

    sync2 u_sync_done (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (prog_done),
        .q     (done_s)
    );

    sync2 u_sync_locked (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (dcm_locked),
        .q     (locked_s)
    );

    logic [PhW-1:0] phase_q;
    logic           prog_clk_q;
    logic           fall_tick;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q    <= '0;
            prog_clk_q <= 1'b0;
        end else if (phase_q == PhMax) begin
            phase_q    <= '0;
            prog_clk_q <= ~prog_clk_q;
        end else begin
            phase_q    <= phase_q + PhW'(1);
        end
    end

    assign fall_tick = (phase_q == PhMax) && prog_clk_q;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  sh_q, sh_d;
    logic [7:0]  m_q, m_d, dv_q, dv_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        prog_en_q, prog_en_d, prog_data_q, prog_data_d;
    logic        done_q, done_d, err_q, err_d, vga_rst_q, vga_rst_d;
    logic [9:0]  frame_dv, frame_m;

    assign frame_dv = frame_bits(CMD_LOAD_D, dv_q);
    assign frame_m  = frame_bits(CMD_LOAD_M, m_q);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        m_d         = m_q;
        dv_d        = dv_q;
        tcnt_d      = tcnt_q;
        prog_en_d   = prog_en_q;
        prog_data_d = prog_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        vga_rst_d   = vga_rst_q;
        unique case (state_q)
            StIdle: begin
                // A pending request waits here for the next fall tick so bit 0 gets a full period.
                if (pending_q) begin
                    if (fall_tick) begin
                        state_d     = StLoadD;
                        pending_d   = 1'b0;
                        prog_en_d   = 1'b1;
                        prog_data_d = frame_dv[9];
                        sh_d        = {frame_dv[8:0], 1'b0};
                        cnt_d       = 4'(FRAME_LEN - 1);
                    end
                end else begin
                    vga_rst_d = ~locked_s;
                    if (start) begin
                        if (cfg_m == 8'd0) begin
                            err_d = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                            m_d       = cfg_m;
                            dv_d      = cfg_d;
                            vga_rst_d = 1'b1;
                        end
                    end
                end
            end
            StLoadD, StLoadM: begin
                if (fall_tick) begin
                    if (cnt_q == 4'd0) begin
                        state_d     = (state_q == StLoadD) ? StGap1 : StGap2;
                        prog_en_d   = 1'b0;
                        prog_data_d = 1'b0;
                        cnt_d       = 4'(GAP_LEN - 1);
                    end else begin
                        prog_data_d = sh_q[9];
                        sh_d        = {sh_q[8:0], 1'b0};
                        cnt_d       = cnt_q - 4'd1;
                    end
                end
            end
            StGap1: begin
                if (fall_tick) begin
                    if (cnt_q == 4'd0) begin
                        state_d     = StLoadM;
                        prog_en_d   = 1'b1;
                        prog_data_d = frame_m[9];
                        sh_d        = {frame_m[8:0], 1'b0};
                        cnt_d       = 4'(FRAME_LEN - 1);
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StGap2: begin
                if (fall_tick) begin
                    if (cnt_q == 4'd0) begin
                        state_d     = StGo;
                        prog_en_d   = 1'b1;
                        prog_data_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StGo: begin
                if (fall_tick) begin
                    state_d   = StWaitDone;
                    prog_en_d = 1'b0;
                    tcnt_d    = '0;
                end
            end
            StWaitDone, StWaitLock: begin
                if (state_q == StWaitDone && done_s) begin
                    state_d = StWaitLock;
                    tcnt_d  = '0;
                end else if (state_q == StWaitLock && locked_s) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    vga_rst_d = 1'b0;
                end else if (tcnt_q == TmoLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            m_q         <= '0;
            dv_q        <= '0;
            tcnt_q      <= '0;
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            vga_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            m_q         <= m_d;
            dv_q        <= dv_d;
            tcnt_q      <= tcnt_d;
            prog_en_q   <= prog_en_d;
            prog_data_q <= prog_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            vga_rst_q   <= vga_rst_d;
        end
    end

    assign busy      = (state_q != StIdle) || pending_q;
    assign done      = done_q;
    assign err       = err_q;
    assign prog_clk  = prog_clk_q;
    assign prog_en   = prog_en_q;
    assign prog_data = prog_data_q;
    assign vga_rst   = vga_rst_q;

endmodule

// File: tb/tb_vga_clkgen_prog.sv
// Scoreboard bench: stimulus pushes expected serial bits and completion events;
// a negedge monitor decodes prog_clk rising edges and done/err pulses against them.
module tb_vga_clkgen_prog;

    localparam int MODE_NORMAL   = 0;
    localparam int MODE_TIMEOUT  = 1;
    localparam int MODE_MIDSTART = 2;
    localparam int EV_DONE       = 0;
    localparam int EV_ERR        = 1;
    localparam int SEQ_BITS      = 25;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       start;
    logic [7:0] cfg_m, cfg_d;
    logic       busy, done, err, prog_clk, prog_en, prog_data;
    logic       prog_done, dcm_locked, vga_rst;

    int n_checks = 0;
    int n_pass   = 0;

    // {data_is_checked, prog_en, prog_data}
    logic [2:0] exp_bits[$];
    int         exp_evt[$];

    vga_clkgen_prog #(
        .CLK_DIV (2),
        .TIMEOUT (64)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .cfg_m      (cfg_m),
        .cfg_d      (cfg_d),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .prog_clk   (prog_clk),
        .prog_en    (prog_en),
        .prog_data  (prog_data),
        .prog_done  (prog_done),
        .dcm_locked (dcm_locked),
        .vga_rst    (vga_rst)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    // Reference stream: command MSB first, value LSB first, gaps, GO.
    task automatic push_frame(input logic [1:0] cmd, input logic [7:0] v);
        logic b;
        for (int i = 0; i < 10; i++) begin
            if (i < 2) b = cmd[1-i];
            else       b = v[i-2];
            exp_bits.push_back({1'b1, 1'b1, b});
        end
    endtask

    task automatic push_seq(input logic [7:0] d, input logic [7:0] m);
        push_frame(2'b10, d);
        exp_bits.push_back(3'b100);
        exp_bits.push_back(3'b100);
        push_frame(2'b11, m);
        exp_bits.push_back(3'b000);
        exp_bits.push_back(3'b000);
        exp_bits.push_back(3'b110);
    endtask

    // Monitor
    logic       prev_pclk = 1'b0;
    logic       prev_done = 1'b0;
    int         frame_idx = 0;
    logic [2:0] mon_e;
    int         mon_ev;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_pclk = 1'b0;
            prev_done = 1'b0;
            frame_idx = 0;
        end else begin
            if (prog_clk && !prev_pclk && (prog_en || frame_idx != 0)) begin
                if (exp_bits.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_bit: prog_en=%0b prog_data=%0b, required no frame at %0t",
                             prog_en, prog_data, $time);
                end else begin
                    mon_e = exp_bits.pop_front();
                    check("bit_en", int'(prog_en), int'(mon_e[1]));
                    if (mon_e[2]) check("bit_data", int'(prog_data), int'(mon_e[0]));
                end
                frame_idx = (frame_idx == SEQ_BITS - 1) ? 0 : frame_idx + 1;
            end
            if (done || err) begin
                check("done_err_exclusive", int'(done & err), 0);
                if (done) check("done_width", int'(prev_done), 0);
                if (exp_evt.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: done=%0b err=%0b, required none at %0t",
                             done, err, $time);
                end else begin
                    mon_ev = exp_evt.pop_front();
                    check("event_is_err", int'(err), (mon_ev == EV_ERR) ? 1 : 0);
                    check("busy_at_end", int'(busy), 0);
                    if (done) check("vga_rst_at_done", int'(vga_rst), 0);
                end
            end
            prev_pclk = prog_clk;
            prev_done = done;
        end
    end

    task automatic wait_bits(input int remaining, input int budget);
        int k = 0;
        while (exp_bits.size() > remaining && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check("frame_progress", exp_bits.size(), remaining);
    endtask

    task automatic run_seq(input logic [7:0] d, input logic [7:0] m, input int mode);
        int   k;
        logic seen;
        @(posedge sys_clk); #1;
        cfg_d = d; cfg_m = m; start = 1'b1;
        if (m == 8'd0) begin
            exp_evt.push_back(EV_ERR);
        end else begin
            push_seq(d, m);
            exp_evt.push_back((mode == MODE_TIMEOUT) ? EV_ERR : EV_DONE);
        end
        @(posedge sys_clk); #1;
        start = 1'b0; cfg_d = 8'($urandom); cfg_m = 8'($urandom);
        if (m == 8'd0) begin
            check("reject_err", int'(err), 1);
            check("reject_busy", int'(busy), 0);
            seen = 1'b0;
            repeat (40) begin
                @(posedge sys_clk); #1;
                seen = seen | busy | prog_en;
            end
            check("reject_stays_idle", int'(seen), 0);
            return;
        end
        check("accept_busy", int'(busy), 1);
        check("accept_vga_rst", int'(vga_rst), 1);
        dcm_locked = 1'b0;
        if (mode == MODE_MIDSTART) begin
            wait_bits(11, 1000);
            @(posedge sys_clk); #1;
            start = 1'b1; cfg_m = ~m; cfg_d = ~d;
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        wait_bits(0, 1000);
        if (mode == MODE_TIMEOUT) begin
            k = 0;
            while (prog_clk && k < 20) begin
                @(negedge sys_clk);
                k++;
            end
            k = 0;
            while (k < 200) begin
                @(negedge sys_clk);
                k++;
                if (err) break;
            end
            check("timeout_latency", k, 64);
            check("timeout_busy", int'(busy), 0);
            check("timeout_vga_rst", int'(vga_rst), 1);
            return;
        end
        repeat ($urandom_range(5, 40)) @(posedge sys_clk);
        #1 prog_done = 1'b1;
        repeat ($urandom_range(3, 30)) @(posedge sys_clk);
        #1 dcm_locked = 1'b1;
        k = 0;
        while (exp_evt.size() != 0 && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check("seq_complete", exp_evt.size(), 0);
        prog_done = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 check("post_done_vga_rst", int'(vga_rst), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_prog_clk"}, int'(prog_clk), 0);
        check({tag, "_prog_en"}, int'(prog_en), 0);
        check({tag, "_prog_data"}, int'(prog_data), 0);
        check({tag, "_vga_rst"}, int'(vga_rst), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, rm;
        sys_rst_n = 1'b0; start = 1'b0; cfg_m = '0; cfg_d = '0;
        prog_done = 1'b0; dcm_locked = 1'b1;
        #12 check_reset_outputs("reset");
        #4 sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1 check("idle_locked_vga_rst", int'(vga_rst), 0);

        run_seq(8'h03, 8'h07, MODE_NORMAL);
        run_seq(8'h5a, 8'h00, MODE_NORMAL);
        run_seq(8'($urandom), 8'($urandom_range(1, 255)), MODE_TIMEOUT);

        // Lock returns after a timeout, then drops and returns while idle.
        @(posedge sys_clk); #1 dcm_locked = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 check("relock_vga_rst", int'(vga_rst), 0);
        dcm_locked = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 check("unlock_vga_rst", int'(vga_rst), 1);
        dcm_locked = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 check("lock_back_vga_rst", int'(vga_rst), 0);

        run_seq(8'($urandom), 8'($urandom_range(1, 255)), MODE_MIDSTART);

        // Reset while LOAD_D bit 5 is on the wire.
        rd = 8'($urandom); rm = 8'($urandom_range(1, 255));
        @(posedge sys_clk); #1;
        cfg_d = rd; cfg_m = rm; start = 1'b1;
        push_seq(rd, rm);
        @(posedge sys_clk); #1 start = 1'b0;
        wait_bits(20, 1000);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_bits.delete();
        exp_evt.delete();
        dcm_locked = 1'b1;
        #4 sys_rst_n = 1'b1;
        repeat (4) @(posedge sys_clk);
        run_seq(8'($urandom), 8'($urandom_range(1, 255)), MODE_NORMAL);

        for (int i = 0; i < 6; i++) begin
            rm = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_seq(8'($urandom), rm, ($urandom_range(0, 1) == 0) ? MODE_NORMAL : MODE_MIDSTART);
        end

        repeat (10) @(posedge sys_clk);
        check("leftover_bits", exp_bits.size(), 0);
        check("leftover_events", exp_evt.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
